pc_redirect_arb: RTL and testbench

- Registered, parametrised successor to the IFU fixed-priority PC-redirect arbiter.
- Accepts up to SRC_NUM redirect requests, each carrying a next-PC. Source SRC_NUM-1 (EXU) has the highest priority and source 0 (IF0) the lowest.
- Presents one registered redirect to the PC generator with a valid/ready hold, plus a flush mask for the younger stages.
- After a redirect, masks younger-stage requests for a squash window, because those requests come from the wrong path.

---
 rtl/pc_redirect_arb_pkg.sv | 22 ++
 rtl/pc_redirect_arb_prio.sv | 27 ++
 rtl/pc_redirect_arb.sv | 151 +++++++++++++++
 tb/tb_pc_redirect_arb.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_arb_pkg.sv
// Shared constants and types for the IFU PC-redirect path.
package risXv_macro;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned REDIR_SRC_NUM = 4;

  localparam int unsigned REDIR_IF0 = 0;
  localparam int unsigned REDIR_IF1 = 1;
  localparam int unsigned REDIR_IF2 = 2;
  localparam int unsigned REDIR_EXU = 3;

  typedef enum logic {
    REDIR_IDLE,
    REDIR_HOLD
  } redir_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] npc;
  } redir_req_t;

endpackage

// File: rtl/pc_redirect_arb_prio.sv
// Combinational highest-index-first one-hot arbiter with found flag and binary index.
module prio_onehot_arb #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_onehot,
  output logic            o_found,
  output logic [IdxW-1:0] o_idx
);

  // Ascending scan; the last hit (highest index) wins.
  always_comb begin
    o_onehot = '0;
    o_found  = 1'b0;
    o_idx    = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (i_req[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_found     = 1'b1;
        o_idx       = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/pc_redirect_arb.sv
// Registered fixed-priority PC-redirect arbiter with valid/ready hold and squash window.
// Optional per-source grant/drop counters under PC_REDIR_PERF_EN.
module pc_redirect_arb
  import risXv_macro::*;
#(
  parameter int unsigned SRC_NUM    = REDIR_SRC_NUM,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned SQUASH_CYC = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SRC_NUM-1:0]      i_src_valid,
  input  logic [SRC_NUM*PC_W-1:0] i_src_npc,
  input  logic                    i_pcgen_ready,
  output logic [SRC_NUM-1:0]      o_src_grant,
  output logic                    o_redir_valid,
  output logic [PC_W-1:0]         o_redir_npc,
  output logic [SRC_NUM-1:0]      o_redir_src,
  output logic [SRC_NUM-1:0]      o_flush_mask
`ifdef PC_REDIR_PERF_EN
  ,
  output logic [SRC_NUM*16-1:0]   o_perf_acc_cnt,
  output logic [SRC_NUM*16-1:0]   o_perf_drop_cnt
`endif
);

  localparam int unsigned IdxW = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam int unsigned CntW = (SQUASH_CYC > 0) ? $clog2(SQUASH_CYC + 1) : 1;

  redir_state_e      stateQ, stateD;
  logic [IdxW-1:0]   heldIdxQ;
  logic [CntW-1:0]   sqCntQ;
  logic [IdxW-1:0]   sqIdxQ;

  logic [SRC_NUM-1:0] eligible;
  logic [SRC_NUM-1:0] candOh;
  logic               candFound;
  logic [IdxW-1:0]    candIdx;
  logic [SRC_NUM-1:0] flushSel;
  logic [PC_W-1:0]    npcSel;
  logic               accept;

  // Requests below the last winner come from the wrong path while the window is open.
  always_comb begin
    eligible = '0;
    for (int j = 0; j < int'(SRC_NUM); j++) begin
      eligible[j] = i_src_valid[j] & ~((sqCntQ != '0) && (IdxW'(j) < sqIdxQ));
    end
  end

  prio_onehot_arb #(
    .N    (SRC_NUM),
    .IdxW (IdxW)
  ) uCandArb (
    .i_req    (eligible),
    .o_onehot (candOh),
    .o_found  (candFound),
    .o_idx    (candIdx)
  );

  always_comb begin
    npcSel   = '0;
    flushSel = '0;
    for (int j = 0; j < int'(SRC_NUM); j++) begin
      if (candOh[j]) npcSel = i_src_npc[j*PC_W +: PC_W];
      flushSel[j] = (IdxW'(j) < candIdx);
    end
  end

  always_comb begin
    stateD = stateQ;
    accept = 1'b0;
    unique case (stateQ)
      REDIR_IDLE: begin
        if (candFound) begin
          accept = 1'b1;
          stateD = REDIR_HOLD;
        end
      end
      REDIR_HOLD: begin
        if (i_pcgen_ready) begin
          if (candFound) accept = 1'b1;
          else           stateD = REDIR_IDLE;
        end else if (candFound && (candIdx >= heldIdxQ)) begin
          // Older (or same-stage newer) redirect supersedes the held one.
          accept = 1'b1;
        end
      end
      default: stateD = REDIR_IDLE;
    endcase
  end

  assign o_src_grant = accept ? candOh : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stateQ        <= REDIR_IDLE;
      heldIdxQ      <= '0;
      o_redir_valid <= 1'b0;
      o_redir_npc   <= '0;
      o_redir_src   <= '0;
      o_flush_mask  <= '0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        heldIdxQ      <= candIdx;
        o_redir_valid <= 1'b1;
        o_redir_npc   <= npcSel;
        o_redir_src   <= candOh;
        o_flush_mask  <= flushSel;
      end else if (stateD == REDIR_IDLE) begin
        o_redir_valid <= 1'b0;
        o_redir_src   <= '0;
        o_flush_mask  <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sqCntQ <= '0;
      sqIdxQ <= '0;
    end else if (accept) begin
      sqCntQ <= CntW'(SQUASH_CYC);
      sqIdxQ <= candIdx;
    end else if (sqCntQ != '0) begin
      sqCntQ <= sqCntQ - 1'b1;
    end
  end

`ifdef PC_REDIR_PERF_EN
  for (genvar s = 0; s < int'(SRC_NUM); s++) begin : gPerf
    logic [15:0] accQ;
    logic [15:0] dropQ;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        accQ  <= '0;
        dropQ <= '0;
      end else begin
        if (o_src_grant[s] && (accQ != 16'hFFFF)) accQ <= accQ + 16'd1;
        if (i_src_valid[s] && !o_src_grant[s] && (dropQ != 16'hFFFF)) dropQ <= dropQ + 16'd1;
      end
    end

    assign o_perf_acc_cnt[s*16 +: 16]  = accQ;
    assign o_perf_drop_cnt[s*16 +: 16] = dropQ;
  end
`endif

endmodule

// File: tb/tb_pc_redirect_arb.sv
// Directed vector bench for pc_redirect_arb (SRC_NUM=4, PC_W=32, SQUASH_CYC=2).
module tb_pc_redirect_arb;

  logic         clk = 1'b0;
  logic         rstN;
  logic [3:0]   srcValid;
  logic [127:0] srcNpc;
  logic         ready;
  logic [3:0]   grant;
  logic         redirValid;
  logic [31:0]  redirNpc;
  logic [3:0]   redirSrc;
  logic [3:0]   flushMask;
`ifdef PC_REDIR_PERF_EN
  logic [63:0]  perfAcc;
  logic [63:0]  perfDrop;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_redirect_arb #(
    .SRC_NUM    (4),
    .PC_W       (32),
    .SQUASH_CYC (2)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_src_valid   (srcValid),
    .i_src_npc     (srcNpc),
    .i_pcgen_ready (ready),
    .o_src_grant   (grant),
    .o_redir_valid (redirValid),
    .o_redir_npc   (redirNpc),
    .o_redir_src   (redirSrc),
    .o_flush_mask  (flushMask)
`ifdef PC_REDIR_PERF_EN
    ,
    .o_perf_acc_cnt  (perfAcc),
    .o_perf_drop_cnt (perfDrop)
`endif
  );

  // Registered expectations describe the state before this cycle's rising edge.
  typedef struct {
    logic [3:0]   valid;
    logic [127:0] npc;
    logic         rdy;
    logic [3:0]   expGrant;
    logic         expValid;
    logic [31:0]  expNpc;
    logic [3:0]   expSrc;
    logic [3:0]   expFlush;
  } vec_t;

  localparam int NumVec = 28;
  vec_t vecs[NumVec];

  function automatic vec_t mk(input logic [3:0] v, input logic [127:0] n, input logic r,
                              input logic [3:0] g, input logic ev, input logic [31:0] en,
                              input logic [3:0] es, input logic [3:0] ef);
    vec_t t;
    t.valid = v; t.npc = n; t.rdy = r; t.expGrant = g;
    t.expValid = ev; t.expNpc = en; t.expSrc = es; t.expFlush = ef;
    return t;
  endfunction

  function automatic logic [127:0] np(input logic [31:0] a3, input logic [31:0] a2,
                                      input logic [31:0] a1, input logic [31:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // reset state
    vecs[0]  = mk(4'b0000, '0, 1, 4'b0000, 0, 32'h0, 4'b0000, 4'b0000);
    // single IF1 request, ready=1
    vecs[1]  = mk(4'b0010, np(0, 0, 32'h8000_0040, 0), 1, 4'b0010, 0, 32'h0, 4'b0000, 4'b0000);
    vecs[2]  = mk(4'b0000, '0, 1, 4'b0000, 1, 32'h8000_0040, 4'b0010, 4'b0001);
    vecs[3]  = mk(4'b0000, '0, 1, 4'b0000, 0, 32'h0, 4'b0000, 4'b0000);
    // simultaneous IF0/IF2/EXU
    vecs[4]  = mk(4'b1101, np(32'h300, 32'h200, 0, 32'h100), 1, 4'b1000, 0, 0, 4'b0000, 4'b0000);
    vecs[5]  = mk(4'b0000, '0, 1, 4'b0000, 1, 32'h300, 4'b1000, 4'b0111);
    vecs[6]  = mk(4'b0000, '0, 0, 4'b0000, 0, 32'h0, 4'b0000, 4'b0000);
    // hold IF1, EXU overrides, later IF0 never granted, then consume
    vecs[7]  = mk(4'b0010, np(0, 0, 32'h40, 0), 0, 4'b0010, 0, 32'h0, 4'b0000, 4'b0000);
    vecs[8]  = mk(4'b1000, np(32'h900, 0, 0, 0), 0, 4'b1000, 1, 32'h40, 4'b0010, 4'b0001);
    vecs[9]  = mk(4'b0001, np(0, 0, 0, 32'h11), 0, 4'b0000, 1, 32'h900, 4'b1000, 4'b0111);
    vecs[10] = mk(4'b0001, np(0, 0, 0, 32'h11), 0, 4'b0000, 1, 32'h900, 4'b1000, 4'b0111);
    vecs[11] = mk(4'b0001, np(0, 0, 0, 32'h11), 0, 4'b0000, 1, 32'h900, 4'b1000, 4'b0111);
    vecs[12] = mk(4'b0000, '0, 1, 4'b0000, 1, 32'h900, 4'b1000, 4'b0111);
    vecs[13] = mk(4'b0000, '0, 0, 4'b0000, 0, 32'h0, 4'b0000, 4'b0000);
    // squash window: IF2 at T, IF1 masked T+1,T+2, granted T+3
    vecs[14] = mk(4'b0100, np(0, 32'h220, 0, 0), 1, 4'b0100, 0, 32'h0, 4'b0000, 4'b0000);
    vecs[15] = mk(4'b0010, np(0, 0, 32'h110, 0), 1, 4'b0000, 1, 32'h220, 4'b0100, 4'b0011);
    vecs[16] = mk(4'b0010, np(0, 0, 32'h110, 0), 1, 4'b0000, 0, 32'h0, 4'b0000, 4'b0000);
    vecs[17] = mk(4'b0010, np(0, 0, 32'h110, 0), 1, 4'b0010, 0, 32'h0, 4'b0000, 4'b0000);
    vecs[18] = mk(4'b0000, '0, 1, 4'b0000, 1, 32'h110, 4'b0010, 4'b0001);
    vecs[19] = mk(4'b0000, '0, 1, 4'b0000, 0, 32'h0, 4'b0000, 4'b0000);
    // EXU inside the window is granted at once; IF1 stays masked
    vecs[20] = mk(4'b0100, np(0, 32'h220, 0, 0), 0, 4'b0100, 0, 32'h0, 4'b0000, 4'b0000);
    vecs[21] = mk(4'b1010, np(32'h930, 0, 32'h110, 0), 0, 4'b1000, 1, 32'h220, 4'b0100, 4'b0011);
    // back-to-back EXU with ready=1
    vecs[22] = mk(4'b1000, np(32'h940, 0, 0, 0), 1, 4'b1000, 1, 32'h930, 4'b1000, 4'b0111);
    vecs[23] = mk(4'b0000, '0, 1, 4'b0000, 1, 32'h940, 4'b1000, 4'b0111);
    vecs[24] = mk(4'b0000, '0, 1, 4'b0000, 0, 32'h0, 4'b0000, 4'b0000);
    // same-index replacement while stalled
    vecs[25] = mk(4'b0100, np(0, 32'h250, 0, 0), 0, 4'b0100, 0, 32'h0, 4'b0000, 4'b0000);
    vecs[26] = mk(4'b0100, np(0, 32'h260, 0, 0), 0, 4'b0100, 1, 32'h250, 4'b0100, 4'b0011);
    vecs[27] = mk(4'b0000, '0, 0, 4'b0000, 1, 32'h260, 4'b0100, 4'b0011);

    rstN     = 1'b0;
    srcValid = '0;
    srcNpc   = '0;
    ready    = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    for (int k = 0; k < NumVec; k++) begin
      @(negedge clk);
      srcValid = vecs[k].valid;
      srcNpc   = vecs[k].npc;
      ready    = vecs[k].rdy;
      #1;
      chk("grant", k, 32'(grant), 32'(vecs[k].expGrant));
      chk("redir_valid", k, 32'(redirValid), 32'(vecs[k].expValid));
      chk("redir_src", k, 32'(redirSrc), 32'(vecs[k].expSrc));
      chk("flush_mask", k, 32'(flushMask), 32'(vecs[k].expFlush));
      if (vecs[k].expValid) chk("redir_npc", k, redirNpc, vecs[k].expNpc);
    end

    // Async reset mid-HOLD, between clock edges.
    @(negedge clk);
    srcValid = '0;
    ready    = 1'b0;
    #2;
    chk("pre_reset_valid", 100, 32'(redirValid), 32'd1);
    rstN = 1'b0;
    #1;
    chk("rst_valid", 101, 32'(redirValid), 32'd0);
    chk("rst_npc", 101, redirNpc, 32'h0);
    chk("rst_src", 101, 32'(redirSrc), 32'd0);
    chk("rst_flush", 101, 32'(flushMask), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Squash window must also be cleared by reset, so IF0 wins immediately.
    @(negedge clk);
    srcValid = 4'b0001;
    srcNpc   = np(0, 0, 0, 32'h44);
    ready    = 1'b1;
    #1;
    chk("post_rst_grant", 102, 32'(grant), 32'b0001);
    @(negedge clk);
    srcValid = '0;
    #1;
    chk("post_rst_valid", 103, 32'(redirValid), 32'd1);
    chk("post_rst_npc", 103, redirNpc, 32'h44);
    chk("post_rst_src", 103, 32'(redirSrc), 32'b0001);
    chk("post_rst_flush", 103, 32'(flushMask), 32'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
